// File: rtl/boron_key_schedule_seq_if.sv
// Handshake bundle for the BORON key-schedule engine: master-key input side
// and round-key output side. The master modport is the producer/consumer; slave is the engine.
interface boron_key_schedule_seq_if #(
  parameter int KEY_W = 80
);
  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key_in;
  logic             key_dec;
  logic             rk_valid;
  logic             rk_ready;
  logic [63:0]      rk_out;
  logic [4:0]       rk_idx;
  logic             rk_last;
  logic             busy;

  modport master (
    output key_valid, key_in, key_dec, rk_ready,
    input  key_ready, rk_valid, rk_out, rk_idx, rk_last, busy
  );

  modport slave (
    input  key_valid, key_in, key_dec, rk_ready,
    output key_ready, rk_valid, rk_out, rk_idx, rk_last, busy
  );
endinterface

// File: rtl/boron_key_schedule_seq.sv
// Sequential BORON key schedule: accepts a master key and streams ROUNDS+1 round keys.
// Define BORON_KS_REVERSE_EN to compile in the round-key buffer and reverse (decryption) order.
module boron_key_schedule_seq #(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 25
) (
  input logic                     clk,
  input logic                     rst,
  boron_key_schedule_seq_if.slave ks
);

  if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key_w
    $error("boron_key_schedule_seq: KEY_W must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("boron_key_schedule_seq: ROUNDS must be in 1..31");
  end

  localparam logic [4:0] LAST_IDX = 5'(ROUNDS);

`ifdef BORON_KS_REVERSE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FILL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [4:0]       idx_q, idx_d;

`ifdef BORON_KS_REVERSE_EN
  logic             dec_q, dec_d;
  logic [63:0]      buf_q [0:ROUNDS];
  logic [63:0]      buf_d [0:ROUNDS];
`else
  logic             unused_key_dec;
  assign unused_key_dec = ks.key_dec;
`endif

  function automatic logic [3:0] s_box(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hB;  4'h3: y = 4'h1;
      4'h4: y = 4'h7;  4'h5: y = 4'h9;  4'h6: y = 4'hC;  4'h7: y = 4'hA;
      4'h8: y = 4'hD;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'hF;
      4'hC: y = 4'h8;  4'hD: y = 4'h5;  4'hE: y = 4'h3;  default: y = 4'h6;
    endcase
    return y;
  endfunction

  // One key-state update: rotate left 13, S-box the low nibble(s), mix in the round number.
  function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                  input logic [4:0]       r);
    logic [KEY_W-1:0] t;
    t = {k[KEY_W-14:0], k[KEY_W-1:KEY_W-13]};
    t[3:0] = s_box(t[3:0]);
    if (KEY_W == 128) begin
      t[7:4] = s_box(t[7:4]);
    end
    t[63:59] = t[63:59] ^ r;
    return t;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
`ifdef BORON_KS_REVERSE_EN
      dec_q   <= 1'b0;
      for (int i = 0; i <= ROUNDS; i++) begin
        buf_q[i] <= '0;
      end
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
`ifdef BORON_KS_REVERSE_EN
      dec_q   <= dec_d;
      buf_q   <= buf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
`ifdef BORON_KS_REVERSE_EN
    dec_d   = dec_q;
    buf_d   = buf_q;
`endif
    case (state_q)
      IDLE: begin
        if (ks.key_valid) begin
          key_d = ks.key_in;
          idx_d = '0;
`ifdef BORON_KS_REVERSE_EN
          dec_d   = ks.key_dec;
          state_d = ks.key_dec ? FILL : STREAM;
`else
          state_d = STREAM;
`endif
        end
      end
`ifdef BORON_KS_REVERSE_EN
      // idx_q counts buffer writes here; it is left at ROUNDS so reverse streaming starts there.
      FILL: begin
        buf_d[idx_q] = key_q[KEY_W-1 -: 64];
        if (idx_q == LAST_IDX) begin
          state_d = STREAM;
        end else begin
          key_d = key_update(key_q, 5'(idx_q + 5'd1));
          idx_d = 5'(idx_q + 5'd1);
        end
      end
`endif
      STREAM: begin
        if (ks.rk_ready) begin
`ifdef BORON_KS_REVERSE_EN
          if (dec_q) begin
            if (idx_q == 5'd0) begin
              state_d = IDLE;
            end else begin
              idx_d = 5'(idx_q - 5'd1);
            end
          end else
`endif
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            key_d = key_update(key_q, 5'(idx_q + 5'd1));
            idx_d = 5'(idx_q + 5'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ks.key_ready = (state_q == IDLE);
    ks.busy      = (state_q != IDLE);
    ks.rk_valid  = (state_q == STREAM);
    ks.rk_idx    = idx_q;
`ifdef BORON_KS_REVERSE_EN
    ks.rk_out    = dec_q ? buf_q[idx_q] : key_q[KEY_W-1 -: 64];
    ks.rk_last   = (state_q == STREAM) && (dec_q ? (idx_q == 5'd0) : (idx_q == LAST_IDX));
`else
    ks.rk_out    = key_q[KEY_W-1 -: 64];
    ks.rk_last   = (state_q == STREAM) && (idx_q == LAST_IDX);
`endif
  end

endmodule

// File: tb/tb_boron_key_schedule_seq.sv
// Scoreboard bench for boron_key_schedule_seq: 80-bit and 128-bit instances,
// expected round keys queued at key issue and checked by per-instance monitors.
module tb_boron_key_schedule_seq;

  localparam int ROUNDS = 25;

  typedef struct packed {
    logic [63:0] rk;
    logic [4:0]  idx;
    logic        last;
  } exp_t;

  localparam logic [3:0] SB [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                     4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   hs80 = 0;
  int   hs128 = 0;
  exp_t exp80 [$];
  exp_t exp128 [$];

  always #5 clk = ~clk;

  boron_key_schedule_seq_if #(.KEY_W(80))  if80 ();
  boron_key_schedule_seq_if #(.KEY_W(128)) if128 ();

  boron_key_schedule_seq #(.KEY_W(80), .ROUNDS(ROUNDS)) dut80 (
    .clk (clk),
    .rst (rst),
    .ks  (if80.slave)
  );

  boron_key_schedule_seq #(.KEY_W(128), .ROUNDS(ROUNDS)) dut128 (
    .clk (clk),
    .rst (rst),
    .ks  (if128.slave)
  );

  function automatic logic [127:0] model_next(input logic [127:0] k, input int w, input int r);
    logic [127:0] mask;
    logic [127:0] t;
    mask = (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
    t = ((k << 13) | (k >> (w - 13))) & mask;
    t[3:0] = SB[t[3:0]];
    if (w == 128) t[7:4] = SB[t[7:4]];
    t[63:59] = t[63:59] ^ r[4:0];
    return t;
  endfunction

  function automatic logic [63:0] model_rk(input logic [127:0] k, input int w);
    logic [127:0] s;
    s = k >> (w - 64);
    return s[63:0];
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_seq(input bit big, input logic [127:0] key, input bit rev);
    exp_t         arr [0:ROUNDS];
    logic [127:0] k;
    int           w;
    w = big ? 128 : 80;
    k = key;
    for (int i = 0; i <= ROUNDS; i++) begin
      if (i > 0) k = model_next(k, w, i);
      arr[i].rk   = model_rk(k, w);
      arr[i].idx  = 5'(i);
      arr[i].last = rev ? (i == 0) : (i == ROUNDS);
    end
    for (int i = 0; i <= ROUNDS; i++) begin
      if (big) exp128.push_back(rev ? arr[ROUNDS - i] : arr[i]);
      else     exp80.push_back(rev ? arr[ROUNDS - i] : arr[i]);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle80(input int budget);
    for (int c = 0; c < budget && if80.busy; c++) step();
    check_output("idle80_timeout", if80.busy, 0);
    check_output("exp80_drained", exp80.size(), 0);
  endtask

  task automatic check_reset80(input string tag);
    @(negedge clk);
    check_output({tag, "_key_ready"}, if80.key_ready, 1);
    check_output({tag, "_rk_valid"},  if80.rk_valid, 0);
    check_output({tag, "_rk_out"},    if80.rk_out, 0);
    check_output({tag, "_rk_idx"},    if80.rk_idx, 0);
    check_output({tag, "_rk_last"},   if80.rk_last, 0);
    check_output({tag, "_busy"},      if80.busy, 0);
  endtask

  // Offer a key in the current cycle; returns one cycle after acceptance with key_valid dropped.
  task automatic apply_stimulus(input logic [79:0] key, input bit dec);
    if80.key_in    = key;
    if80.key_dec   = dec;
    if80.key_valid = 1'b1;
    @(negedge clk);
    check_output("accept_ready", if80.key_ready, 1);
    step();
    if80.key_valid = 1'b0;
  endtask

  // Monitors: compare presented round key with queue front every valid cycle, pop on handshake.
  always @(negedge clk) begin
    if (!rst && if80.rk_valid) begin
      if (exp80.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL rk80_unexpected: got idx %0d, expected no transfer", if80.rk_idx);
      end else begin
        check_output("rk80_out",  if80.rk_out,  exp80[0].rk);
        check_output("rk80_idx",  if80.rk_idx,  exp80[0].idx);
        check_output("rk80_last", if80.rk_last, exp80[0].last);
        if (if80.rk_ready) begin
          void'(exp80.pop_front());
          hs80++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if128.rk_valid) begin
      if (exp128.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL rk128_unexpected: got idx %0d, expected no transfer", if128.rk_idx);
      end else begin
        check_output("rk128_out",  if128.rk_out,  exp128[0].rk);
        check_output("rk128_idx",  if128.rk_idx,  exp128[0].idx);
        check_output("rk128_last", if128.rk_last, exp128[0].last);
        if (if128.rk_ready) begin
          void'(exp128.pop_front());
          hs128++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] big_key;
    int           nvalid;

    if80.key_valid  = 1'b0;
    if80.key_in     = '0;
    if80.key_dec    = 1'b0;
    if80.rk_ready   = 1'b1;
    if128.key_valid = 1'b0;
    if128.key_in    = '0;
    if128.key_dec   = 1'b0;
    if128.rk_ready  = 1'b1;

    rst = 1'b1;
    step(3);
    rst = 1'b0;
    check_reset80("reset");
    @(negedge clk);
    check_output("reset128_ready", if128.key_ready, 1);
    check_output("reset128_out",   if128.rk_out, 0);
    step();

    // Zero key, forward, consumer always ready: hand-computed first keys and timing.
    push_seq(1'b0, 128'd0, 1'b0);
    apply_stimulus(80'd0, 1'b0);
    @(negedge clk);
    check_output("zero_t1_valid", if80.rk_valid, 1);
    check_output("zero_t1_idx",   if80.rk_idx, 0);
    check_output("zero_t1_out",   if80.rk_out, 64'h0000000000000000);
    step();
    @(negedge clk);
    check_output("zero_t2_out",   if80.rk_out, 64'h0000080000000000);
    step();
    @(negedge clk);
    check_output("zero_t3_out",   if80.rk_out, 64'h0100100000000001);
    step(23);
    @(negedge clk);
    check_output("zero_t26_idx",  if80.rk_idx, 25);
    check_output("zero_t26_last", if80.rk_last, 1);
    step();
    @(negedge clk);
    check_output("zero_t27_ready", if80.key_ready, 1);
    check_output("zero_t27_busy",  if80.busy, 0);
    check_output("zero_t27_valid", if80.rk_valid, 0);
    step();

    // Backpressure with a 1,0,0,1 ready pattern.
    hs80 = 0;
    push_seq(1'b0, 128'h0123_4567_89AB_CDEF_0F1E, 1'b0);
    apply_stimulus(80'h0123_4567_89AB_CDEF_0F1E, 1'b0);
    for (int c = 0; c < 200 && if80.busy; c++) begin
      if80.rk_ready = (c % 4 == 0) || (c % 4 == 3);
      step();
    end
    if80.rk_ready = 1'b1;
    check_output("stall_idle", if80.busy, 0);
    check_output("stall_transfers", hs80, ROUNDS + 1);
    check_output("stall_drained", exp80.size(), 0);
    step();

    // key_dec=1: reverse order when the buffer is compiled in, forward otherwise.
`ifdef BORON_KS_REVERSE_EN
    push_seq(1'b0, 128'hFEDC_BA98_7654_3210_A5C3, 1'b1);
    apply_stimulus(80'hFEDC_BA98_7654_3210_A5C3, 1'b1);
    nvalid = 0;
    for (int i = 0; i < ROUNDS + 1; i++) begin
      @(negedge clk);
      if (if80.rk_valid) nvalid++;
      step();
    end
    check_output("rev_fill_valid_cycles", nvalid, 0);
    @(negedge clk);
    check_output("rev_first_valid", if80.rk_valid, 1);
    check_output("rev_first_idx",   if80.rk_idx, 25);
    wait_idle80(100);
`else
    nvalid = 0;
    push_seq(1'b0, 128'hFEDC_BA98_7654_3210_A5C3, 1'b0);
    apply_stimulus(80'hFEDC_BA98_7654_3210_A5C3, 1'b1);
    @(negedge clk);
    check_output("dec_ignored_valid", if80.rk_valid, 1);
    check_output("dec_ignored_idx",   if80.rk_idx, 0);
    wait_idle80(100);
`endif
    step();

    // key_valid held high through streaming: second key taken only after the last handshake.
    push_seq(1'b0, 128'h1111_2222_3333_4444_5555, 1'b0);
    push_seq(1'b0, 128'h9999_AAAA_BBBB_CCCC_DDDD, 1'b0);
    if80.key_in    = 80'h1111_2222_3333_4444_5555;
    if80.key_dec   = 1'b0;
    if80.key_valid = 1'b1;
    @(negedge clk);
    check_output("held_accept_ready", if80.key_ready, 1);
    step();
    if80.key_in = 80'h9999_AAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    check_output("held_ready_low", if80.key_ready, 0);
    check_output("held_busy",      if80.busy, 1);
    step(25);
    @(negedge clk);
    check_output("held_last", if80.rk_last, 1);
    step();
    @(negedge clk);
    check_output("held_u1_ready", if80.key_ready, 1);
    check_output("held_u1_busy",  if80.busy, 0);
    check_output("held_u1_valid", if80.rk_valid, 0);
    step();
    if80.key_valid = 1'b0;
    @(negedge clk);
    check_output("held_second_valid", if80.rk_valid, 1);
    check_output("held_second_idx",   if80.rk_idx, 0);
    wait_idle80(100);
    step();

    // Reset while index 10 is presented, then a fresh forward key.
    push_seq(1'b0, 128'h0F0F_F0F0_1234_5678_9ABC, 1'b0);
    apply_stimulus(80'h0F0F_F0F0_1234_5678_9ABC, 1'b0);
    step(10);
    rst = 1'b1;
    exp80.delete();
    @(negedge clk);
    check_output("rst_at_idx10", if80.rk_idx, 10);
    step();
    rst = 1'b0;
    check_reset80("rst_idx10");
    step();
    push_seq(1'b0, 128'h0000_0000_0000_0000_0001, 1'b0);
    apply_stimulus(80'h0000_0000_0000_0000_0001, 1'b0);
    @(negedge clk);
    check_output("restart_idx", if80.rk_idx, 0);
    wait_idle80(100);
    step();

`ifdef BORON_KS_REVERSE_EN
    // Reset in the middle of FILL.
    push_seq(1'b0, 128'h2468_ACE0_1357_9BDF_0000, 1'b1);
    apply_stimulus(80'h2468_ACE0_1357_9BDF_0000, 1'b1);
    step(4);
    rst = 1'b1;
    exp80.delete();
    step();
    rst = 1'b0;
    check_reset80("rst_fill");
    step();
`endif

    // 128-bit instance with a random key.
    big_key = {$urandom(), $urandom(), $urandom(), $urandom()};
    push_seq(1'b1, big_key, 1'b0);
    if128.key_in    = big_key;
    if128.key_valid = 1'b1;
    step();
    if128.key_valid = 1'b0;
    for (int c = 0; c < 100 && if128.busy; c++) step();
    check_output("k128_idle", if128.busy, 0);
    check_output("k128_transfers", hs128, ROUNDS + 1);
    check_output("k128_drained", exp128.size(), 0);

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/boron_key_schedule_seq.md
# boron_key_schedule_seq

Sequential, parametrised BORON key-schedule engine. Accepts one master key (80- or 128-bit) through a valid/ready handshake. Streams the full set of ROUNDS+1 64-bit round keys to the cipher datapath through a second valid/ready handshake, one per accepted transfer. It replaces per-round combinational key update in the round loop. Optionally it can deliver the round keys in reverse order for decryption.

## Interface
- KEY_W, 80: master key width; legal values 80 or 128 only; any other value is an elaboration error.
- ROUNDS, 25: number of key updates; round keys emitted = ROUNDS+1; legal range 1..31.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- key_valid  in  1  master key offered.
- key_ready  out  1  block can accept a key.
- key_in  in  KEY_W  master key.
- key_dec  in  1  order select, sampled with key: 0 forward, 1 reverse (reverse requires macro).
- rk_valid  out  1  rk_out/rk_idx/rk_last valid.
- rk_ready  in  1  consumer accepts round key.
- rk_out  out  64  round key = K[KEY_W-1:KEY_W-64] of key state for index rk_idx.
- rk_idx  out  5  round-key index 0..ROUNDS.
- rk_last  out  1  high with the final round key of the sequence.
- busy  out  1  high from key acceptance until the last round-key handshake.

## Operation
- Key update K(i) = f(K(i-1), i), for i = 1..ROUNDS:
  - rotate left 13 over KEY_W.
  - S-box (existing s_box) on bits [3:0]; for KEY_W=128 also on bits [7:4].
  - bits [63:59] XOR 5-bit i.
  - All other bits pass through.
- K(0) = key_in.
- States: IDLE, FILL (reverse only), STREAM.
- IDLE:
  - key_ready=1.
  - On key_valid&key_ready, K(0) is loaded, key_dec is captured, and busy=1.
  - Next state is STREAM (forward) or FILL (reverse).
- STREAM forward:
  - Presents index j, starting at 0.
  - On rk_valid&rk_ready: if j==ROUNDS, go to IDLE; else compute K(j+1) and present j+1.
- FILL:
  - Writes K(0) and then K(1)..K(ROUNDS) into the internal round-key buffer, one update per cycle, with rk_valid=0.
  - Then goes to STREAM reverse.
- STREAM reverse: presents indices ROUNDS down to 0 from the buffer; rk_last goes high at index 0.
- Forward: rk_last=1 exactly when rk_idx==ROUNDS.
- Backpressure: while rk_valid&!rk_ready, rk_out, rk_idx and rk_last are held stable.
- key_valid while busy is ignored; key_ready=0.
- No abort input. rst is the only way to cancel a sequence.
- Reset values:
  - state IDLE.
  - key_ready=1 after reset release.
  - rk_valid=0, rk_out=0, rk_idx=0, rk_last=0, busy=0.
  - Internal key register and buffer are cleared to 0.

## Timing
- Key accepted in cycle t.
- Forward: rk_valid=1 with index 0 in cycle t+1. With rk_ready held high, index j appears at t+1+j; there are no bubbles.
- Reverse: FILL occupies cycles t+1..t+1+ROUNDS (ROUNDS+1 buffer writes). rk_valid=1 with index ROUNDS in cycle t+2+ROUNDS.
- Final handshake in cycle u: busy=0, rk_valid=0 and key_ready=1 in cycle u+1. A new key is accepted no earlier than u+1.
- rst asserted in any state: all outputs take reset values at the next edge. Any handshake in that cycle is discarded.

## Configuration
- BORON_KS_REVERSE_EN defined:
  - The (ROUNDS+1)×64 buffer and the FILL state are compiled in.
  - key_dec=1 selects reverse order.
- BORON_KS_REVERSE_EN undefined:
  - No buffer and no FILL state.
  - key_dec is ignored; every key streams forward.

## Test plan
- KEY_W=80, key_in=0, forward, rk_ready=1 -> idx 0 rk_out=0x0000000000000000 at t+1; idx 1 rk_out=0x0000080000000000 at t+2; idx 25 with rk_last=1 at t+26; key_ready=1 at t+27.
- Forward with rk_ready toggling 1,0,0,1 pattern -> rk_out/rk_idx stable during stalls; 26 transfers, none duplicated or skipped; outputs match the reference model.
- KEY_W=128, random key_in -> all 26 round keys match the software model; both low nibbles are S-boxed each update.
- Macro on, KEY_W=80, key_dec=1 -> rk_valid low for 26 cycles after accept; first transfer idx=25, then 24..0; rk_last only at idx 0; values equal the forward run in reverse.
- key_valid held high during streaming -> key_ready=0, second key not taken until the cycle after rk_last handshake.
- rst pulsed at idx 10 (and during FILL) -> next cycle all outputs reset, key_ready=1; a fresh key then restarts at idx 0 (forward).
